// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the microc control unit.
//   - instruction opcodes (OP_*), including the HALT opcode
//   - ALU operation codes (ALU_*)
//   - run-state FSM encoding (state_t)
//   - decoder output bundle (dec_t)
// The UC_STEP_EN macro adds the WAIT state used by single-step mode.
package uc_pkg;

  localparam logic [5:0] OP_LI   = 6'b001000;
  localparam logic [5:0] OP_ADD  = 6'b010000;
  localparam logic [5:0] OP_SUB  = 6'b001100;
  localparam logic [5:0] OP_OR   = 6'b011100;
  localparam logic [5:0] OP_BEQZ = 6'b000010;
  localparam logic [5:0] OP_J    = 6'b000011;
  localparam logic [5:0] OP_B    = 6'b000111;
  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_HALT = 3'd2,
    ST_ERR  = 3'd3
`ifdef UC_STEP_EN
    ,
    ST_WAIT = 3'd4
`endif
  } state_t;

  // Raw decode of one opcode; legal is 0 for HALT and for unknown opcodes.
  typedef struct packed {
    logic       inm;
    logic       abs;
    logic       inc;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/uc_decode.sv
// uc_decode: purely combinational instruction decoder for microc.
// Ports:
//   opcode  in  6      instruction opcode
//   z       in  1      zero flag (selects beqz taken / not taken)
//   dec     out dec_t  mux selects, write enables, ALU op and legal flag
// HALT and unknown opcodes decode to all-zero with legal=0; the run-state
// FSM in uc_ctrl tells the two apart.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output dec_t       dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so that no path
    // leaves a variable unassigned, which would infer a latch.
    dec = '0;
    case (opcode)
      OP_LI:   begin dec.inm = 1'b1; dec.abs = 1'b1; dec.inc = 1'b1; dec.we3 = 1'b1; dec.legal = 1'b1; end
      OP_ADD:  begin dec.abs = 1'b1; dec.inc = 1'b1; dec.we3 = 1'b1; dec.wez = 1'b1; dec.op = ALU_ADD; dec.legal = 1'b1; end
      OP_SUB:  begin dec.abs = 1'b1; dec.inc = 1'b1; dec.we3 = 1'b1; dec.wez = 1'b1; dec.op = ALU_SUB; dec.legal = 1'b1; end
      OP_OR:   begin dec.abs = 1'b1; dec.inc = 1'b1; dec.we3 = 1'b1; dec.wez = 1'b1; dec.op = ALU_OR;  dec.legal = 1'b1; end
      OP_BEQZ: begin
        // Taken branch selects the absolute target; not taken falls through.
        dec.abs   = ~z;
        dec.inc   = ~z;
        dec.legal = 1'b1;
      end
      OP_J:    dec.legal = 1'b1;
      OP_B:    begin dec.abs = 1'b1; dec.legal = 1'b1; end
      OP_NOP:  begin dec.abs = 1'b1; dec.inc = 1'b1; dec.legal = 1'b1; end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/uc_ctrl.sv
// uc_ctrl: sequential control unit for the microc datapath.
// Wraps the opcode decoder in a run-state FSM (IDLE/RUN/HALT/ERR) and counts
// retired instructions in a saturating counter.
// Ports:
//   clk     in  1      system clock, rising edge
//   reset   in  1      synchronous active-high reset, highest priority
//   step    in  1      (UC_STEP_EN only) advance one instruction from WAIT
//   opcode  in  6      instruction opcode
//   z       in  1      zero flag
//   s_abs   out 1      PC mux: 1 = relative/incr, 0 = absolute target
//   s_inc   out 1      PC mux: 1 = PC+1, 0 = branch/jump target
//   s_inm   out 1      write-data mux: 1 = immediate, 0 = ALU
//   we3     out 1      register-file write enable
//   wez     out 1      zero-flag write enable
//   op      out 3      ALU operation
//   pc_en   out 1      PC load enable
//   halted  out 1      FSM is in HALT
//   err     out 1      FSM is in ERR (illegal opcode trapped)
//   icount  out CNT_W  retired instructions, saturating
// Macro UC_STEP_EN: single-step mode; RUN executes one instruction and then
// parks in WAIT until step=1.
module uc_ctrl
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef UC_STEP_EN
  input  logic             step,
`endif
  input  logic [5:0]       opcode,
  input  logic             z,
  output logic             s_abs,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op,
  output logic             pc_en,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] icount
);

  state_t state, state_nx;
  dec_t   dec;
  logic   retire;

  uc_decode u_decode (
    .opcode (opcode),
    .z      (z),
    .dec    (dec)
  );

  // HALT is not in the decode table, so legal already excludes it.
  assign retire = (state == ST_RUN) && dec.legal;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = ST_RUN;
      ST_RUN: begin
        if (opcode == OP_HALT) state_nx = ST_HALT;
        else if (!dec.legal)   state_nx = ST_ERR;
`ifdef UC_STEP_EN
        else                   state_nx = ST_WAIT;
`endif
      end
`ifdef UC_STEP_EN
      ST_WAIT: if (step) state_nx = ST_RUN;
`endif
      ST_HALT: state_nx = ST_HALT;
      ST_ERR:  state_nx = ST_ERR;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are the raw decode gated by "retiring this cycle"; the HALT and
  // ERR trap cycles therefore carry no side effects.
  always_comb begin
    s_inm  = 1'b0;
    s_abs  = 1'b0;
    s_inc  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    op     = ALU_NONE;
    pc_en  = 1'b0;
    if (retire) begin
      s_inm = dec.inm;
      s_abs = dec.abs;
      s_inc = dec.inc;
      we3   = dec.we3;
      wez   = dec.wez;
      op    = dec.op;
      pc_en = 1'b1;
    end
  end

  assign halted = (state == ST_HALT);
  assign err    = (state == ST_ERR);

  always_ff @(posedge clk) begin
    if (reset)                        icount <= '0;
    else if (retire && (icount != '1)) icount <= icount + CNT_W'(1);
  end

endmodule
